// File: rtl/sram_bist_pkg.sv
// Shared state encoding and March C- element table for the SRAM march BIST engine.
// Purely declarative; no timing or flow-control behaviour of its own.
package sram_bist_pkg;

    localparam int ERR_W     = 16;
    localparam int NUM_ELEMS = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic up;      // address direction: 1 = ascending
        logic rd_inv;  // expected read data is ~pattern
        logic has_wr;  // element writes after its read
        logic wr_inv;  // written data is ~pattern
    } elem_t;

    localparam elem_t MARCH_C [NUM_ELEMS] = '{
        '{up: 1'b1, rd_inv: 1'b0, has_wr: 1'b1, wr_inv: 1'b0},  // M0 up   w0
        '{up: 1'b1, rd_inv: 1'b0, has_wr: 1'b1, wr_inv: 1'b1},  // M1 up   r0 w1
        '{up: 1'b1, rd_inv: 1'b1, has_wr: 1'b1, wr_inv: 1'b0},  // M2 up   r1 w0
        '{up: 1'b0, rd_inv: 1'b0, has_wr: 1'b1, wr_inv: 1'b1},  // M3 down r0 w1
        '{up: 1'b0, rd_inv: 1'b1, has_wr: 1'b1, wr_inv: 1'b0},  // M4 down r1 w0
        '{up: 1'b1, rd_inv: 1'b0, has_wr: 1'b0, wr_inv: 1'b0}   // M5 up   r0
    };

    function automatic elem_t march_elem(input logic [2:0] idx);
        march_elem = MARCH_C[0];
        if (int'(idx) < NUM_ELEMS) march_elem = MARCH_C[idx];
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down march address counter with load to 0 or depth_m1; last flags the final address.
// Counter updates one cycle after load/step; no backpressure, caller sequences it.
module sram_bist_addr_gen #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load,
    input  logic                  load_up,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] depth_m1,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic up_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr <= '0;
            up_q <= 1'b1;
        end else if (load) begin
            addr <= load_up ? '0 : depth_m1;
            up_q <= load_up;
        end else if (step) begin
            addr <= up_q ? addr + ADDR_WIDTH'(1) : addr - ADDR_WIDTH'(1);
        end
    end

    // Elements end on equality with the far bound, never by wrapping.
    assign last = up_q ? (addr == depth_m1) : (addr == '0);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST engine driving a shared SRAM port-0 bus, one macro at a time, with result capture.
// All outputs registered; read data checked READ_LATENCY cycles after issue; no backpressure.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int WMASK_WIDTH  = 4,
    parameter int NUM_SRAMS    = 16,
    parameter int READ_LATENCY = 1,
    parameter int SEL_WIDTH    = $clog2(NUM_SRAMS)
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            start,
    input  logic [SEL_WIDTH-1:0]            sram_sel,
    input  logic [ADDR_WIDTH-1:0]           depth_m1,
    input  logic [DATA_WIDTH-1:0]           pattern,
    input  logic                            stop_on_fail,
    input  logic [NUM_SRAMS*DATA_WIDTH-1:0] dout_in,
    output logic [ADDR_WIDTH-1:0]           addr0,
    output logic [DATA_WIDTH-1:0]           din0,
    output logic                            web0,
    output logic [WMASK_WIDTH-1:0]          wmask0,
    output logic [NUM_SRAMS-1:0]            csb0,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [ERR_W-1:0]                err_count,
    output logic [ADDR_WIDTH-1:0]           fail_addr,
    output logic [DATA_WIDTH-1:0]           fail_data,
    output logic [2:0]                      fail_element
);

    localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t                  state, state_nxt;
    logic [2:0]              elem, elem_nxt;
    logic [WCW-1:0]          wcnt, wcnt_nxt;
    logic                    abort, abort_nxt;
    logic [SEL_WIDTH-1:0]    sel_r;
    logic [ADDR_WIDTH-1:0]   depth_r;
    logic [DATA_WIDTH-1:0]   pat_r;
    logic                    sof_r;
    logic                    latch;

    logic [NUM_SRAMS-1:0]    csb_nxt;
    logic                    web_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [WMASK_WIDTH-1:0]  wmask_nxt;
    logic [DATA_WIDTH-1:0]   din_nxt, fdata_nxt;
    logic [ERR_W-1:0]        err_nxt;
    logic [ADDR_WIDTH-1:0]   faddr_nxt;
    logic [2:0]              felem_nxt;

    logic                    ag_load, ag_load_up, ag_step, ag_last;
    logic [DATA_WIDTH-1:0]   rd_word, exp_word, wr_word;
    logic                    mismatch;

    function automatic logic [NUM_SRAMS-1:0] cs_for(input logic [SEL_WIDTH-1:0] s);
        cs_for = '1;
        for (int k = 0; k < NUM_SRAMS; k++)
            if (s == SEL_WIDTH'(k)) cs_for[k] = 1'b0;
    endfunction

    sram_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk      (clk),
        .resetn   (resetn),
        .load     (ag_load),
        .load_up  (ag_load_up),
        .step     (ag_step),
        .depth_m1 (depth_r),
        .addr     (addr0),
        .last     (ag_last)
    );

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_SRAMS; k++)
            if (sel_r == SEL_WIDTH'(k)) rd_word = dout_in[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign exp_word = march_elem(elem).rd_inv ? ~pat_r : pat_r;
    assign wr_word  = march_elem(elem).wr_inv ? ~pat_r : pat_r;
    assign mismatch = (rd_word != exp_word);

    always_comb begin
        state_nxt  = state;
        elem_nxt   = elem;
        wcnt_nxt   = wcnt;
        abort_nxt  = abort;
        csb_nxt    = '1;
        web_nxt    = 1'b1;
        wmask_nxt  = wmask0;
        din_nxt    = din0;
        busy_nxt   = busy;
        done_nxt   = done;
        pass_nxt   = pass;
        err_nxt    = err_count;
        faddr_nxt  = fail_addr;
        fdata_nxt  = fail_data;
        felem_nxt  = fail_element;
        latch      = 1'b0;
        ag_load    = 1'b0;
        ag_load_up = 1'b1;
        ag_step    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    latch     = 1'b1;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                    err_nxt   = '0;
                    faddr_nxt = '0;
                    fdata_nxt = '0;
                    felem_nxt = '0;
                    elem_nxt  = '0;
                    abort_nxt = 1'b0;
                    if (int'(sram_sel) >= NUM_SRAMS) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_WRITE;
                        busy_nxt  = 1'b1;
                        ag_load   = 1'b1;
                        csb_nxt   = cs_for(sram_sel);
                        web_nxt   = 1'b0;
                        wmask_nxt = '1;
                        din_nxt   = pattern;
                    end
                end
            end
            S_WRITE: begin
                csb_nxt = cs_for(sel_r);
                if (ag_last) begin
                    state_nxt  = S_READ;
                    elem_nxt   = 3'd1;
                    ag_load    = 1'b1;
                    ag_load_up = march_elem(3'd1).up;
                end else begin
                    ag_step = 1'b1;
                    web_nxt = 1'b0;
                    din_nxt = pat_r;
                end
            end
            S_READ: begin
                state_nxt = S_WAIT;
                wcnt_nxt  = WCW'(READ_LATENCY - 1);
            end
            S_WAIT: begin
                if (wcnt != '0) begin
                    wcnt_nxt = wcnt - 1'b1;
                end else begin
                    state_nxt = S_CMP;
                    if (mismatch) begin
                        if (err_count != '1) err_nxt = err_count + 1'b1;
                        if (err_count == '0) begin
                            faddr_nxt = addr0;
                            fdata_nxt = rd_word;
                            felem_nxt = elem;
                        end
                    end
                    // An abort suppresses the element's write in the compare cycle.
                    if (mismatch && sof_r) begin
                        abort_nxt = 1'b1;
                    end else if (march_elem(elem).has_wr) begin
                        csb_nxt = cs_for(sel_r);
                        web_nxt = 1'b0;
                        din_nxt = wr_word;
                    end
                end
            end
            S_CMP: begin
                if (abort || (ag_last && elem == 3'(NUM_ELEMS - 1))) begin
                    state_nxt = S_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_count == '0);
                end else begin
                    state_nxt = S_READ;
                    csb_nxt   = cs_for(sel_r);
                    if (ag_last) begin
                        elem_nxt   = elem + 3'd1;
                        ag_load    = 1'b1;
                        ag_load_up = march_elem(elem + 3'd1).up;
                    end else begin
                        ag_step = 1'b1;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            elem         <= '0;
            wcnt         <= '0;
            abort        <= 1'b0;
            sel_r        <= '0;
            depth_r      <= '0;
            pat_r        <= '0;
            sof_r        <= 1'b0;
            csb0         <= '1;
            web0         <= 1'b1;
            wmask0       <= '0;
            din0         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_addr    <= '0;
            fail_data    <= '0;
            fail_element <= '0;
        end else begin
            state        <= state_nxt;
            elem         <= elem_nxt;
            wcnt         <= wcnt_nxt;
            abort        <= abort_nxt;
            csb0         <= csb_nxt;
            web0         <= web_nxt;
            wmask0       <= wmask_nxt;
            din0         <= din_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            pass         <= pass_nxt;
            err_count    <= err_nxt;
            fail_addr    <= faddr_nxt;
            fail_data    <= fdata_nxt;
            fail_element <= felem_nxt;
            if (latch) begin
                sel_r   <= sram_sel;
                depth_r <= depth_m1;
                pat_r   <= pattern;
                sof_r   <= stop_on_fail;
            end
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: SRAM macro models with a stuck-at-1 fault, table of vectors, reset corner.
module tb_sram_march_bist;

    localparam int NS = 16;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int RL = 1;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               start = 1'b0;
    logic [4:0]         sram_sel = '0;
    logic [AW-1:0]      depth_m1 = '0;
    logic [DW-1:0]      pattern = '0;
    logic               stop_on_fail = 1'b0;
    logic [NS*DW-1:0]   dout;
    logic [AW-1:0]      addr0;
    logic [DW-1:0]      din0;
    logic               web0;
    logic [3:0]         wmask0;
    logic [NS-1:0]      csb0;
    logic               busy, done, pass;
    logic [15:0]        err_count;
    logic [AW-1:0]      fail_addr;
    logic [DW-1:0]      fail_data;
    logic [2:0]         fail_element;

    bit                 fault_en = 1'b0;
    int                 fault_macro = 0;
    logic [AW-1:0]      fault_addr = '0;
    logic [DW-1:0]      fault_mask = '0;

    int n_chk  = 0;
    int n_fail = 0;

    sram_march_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(4),
        .NUM_SRAMS(NS), .READ_LATENCY(RL), .SEL_WIDTH(5)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .sram_sel(sram_sel),
        .depth_m1(depth_m1), .pattern(pattern), .stop_on_fail(stop_on_fail),
        .dout_in(dout), .addr0(addr0), .din0(din0), .web0(web0), .wmask0(wmask0),
        .csb0(csb0), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_addr(fail_addr), .fail_data(fail_data), .fail_element(fail_element)
    );

    always #5 clk = ~clk;

    // Macro models: synchronous port 0, one-cycle read, optional stuck-at-1 bits on one word.
    logic [DW-1:0] mem [NS][1<<AW];
    logic [DW-1:0] wtmp;
    always @(posedge clk) begin
        for (int k = 0; k < NS; k++) begin
            if (!csb0[k]) begin
                if (!web0) begin
                    wtmp = mem[k][addr0];
                    for (int b = 0; b < 4; b++)
                        if (wmask0[b]) wtmp[b*8 +: 8] = din0[b*8 +: 8];
                    mem[k][addr0] <= wtmp;
                end else begin
                    dout[k*DW +: DW] <= mem[k][addr0] |
                        ((fault_en && k == fault_macro && addr0 == fault_addr) ? fault_mask : '0);
                end
            end
        end
    end

    typedef struct {
        logic [4:0]    sel;
        logic [AW-1:0] depth;
        logic [DW-1:0] pat;
        bit            sof;
        bit            fault;
        logic [AW-1:0] faddr;
        logic [DW-1:0] fmask;
        int            e_busy;
        bit            e_pass;
        int            e_err;
        logic [AW-1:0] e_faddr;
        logic [DW-1:0] e_fdata;
        logic [2:0]    e_felem;
        int            e_acc;
    } vec_t;

    function automatic vec_t mk(input int sel, input int depth, input logic [DW-1:0] pat,
                                input bit sof, input bit fault, input int faddr,
                                input logic [DW-1:0] fmask, input int e_busy, input bit e_pass,
                                input int e_err, input int e_faddr, input logic [DW-1:0] e_fdata,
                                input int e_felem, input int e_acc);
        vec_t v;
        v.sel = 5'(sel); v.depth = AW'(depth); v.pat = pat; v.sof = sof;
        v.fault = fault; v.faddr = AW'(faddr); v.fmask = fmask;
        v.e_busy = e_busy; v.e_pass = e_pass; v.e_err = e_err; v.e_faddr = AW'(e_faddr);
        v.e_fdata = e_fdata; v.e_felem = 3'(e_felem); v.e_acc = e_acc;
        return v;
    endfunction

    // Reference: walk March C- over a word array, counting cycles, accesses and mismatches.
    function automatic vec_t model(input vec_t v);
        logic [DW-1:0] m [64];
        logic [DW-1:0] rd, ex;
        int  d = int'(v.depth) + 1;
        int  a;
        bit  stop = 0;
        v.e_err = 0; v.e_faddr = '0; v.e_fdata = '0; v.e_felem = '0;
        v.e_busy = d; v.e_acc = d;
        for (int i = 0; i < d; i++) m[i] = v.pat;
        for (int e = 1; e <= 5 && !stop; e++) begin
            for (int p = 0; p < d && !stop; p++) begin
                a  = (e == 3 || e == 4) ? d - 1 - p : p;
                rd = m[a] | ((v.fault && a == int'(v.faddr)) ? v.fmask : '0);
                ex = (e == 2 || e == 4) ? ~v.pat : v.pat;
                v.e_busy += 2 + RL;
                v.e_acc++;
                if (rd != ex) begin
                    if (v.e_err == 0) begin
                        v.e_faddr = AW'(a); v.e_fdata = rd; v.e_felem = 3'(e);
                    end
                    v.e_err++;
                    if (v.sof) stop = 1;
                end
                if (!stop && e != 5) begin
                    m[a] = (e == 1 || e == 3) ? ~v.pat : v.pat;
                    v.e_acc++;
                end
            end
        end
        v.e_pass = (v.e_err == 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_csb0"}, 64'(csb0), 64'hFFFF);
        chk({tag, "_web0"}, 64'(web0), 1);
        chk({tag, "_addr0"}, 64'(addr0), 0);
        chk({tag, "_din0"}, 64'(din0), 0);
        chk({tag, "_wmask0"}, 64'(wmask0), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_pass"}, 64'(pass), 0);
        chk({tag, "_err"}, 64'(err_count), 0);
        chk({tag, "_faddr"}, 64'(fail_addr), 0);
        chk({tag, "_fdata"}, 64'(fail_data), 0);
        chk({tag, "_felem"}, 64'(fail_element), 0);
    endtask

    task automatic launch(input vec_t v);
        @(negedge clk);
        fault_en = v.fault; fault_macro = int'(v.sel);
        fault_addr = v.faddr; fault_mask = v.fmask;
        sram_sel = v.sel; depth_m1 = v.depth; pattern = v.pat; stop_on_fail = v.sof;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sram_sel = 5'($urandom); depth_m1 = AW'($urandom);
        pattern = $urandom; stop_on_fail = 1'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc = 0, acc = 0, foreign = 0, multi = 0, badmask = 0, nlow;
        bit seen_done = 0, busy_at_done = 0;
        launch(v);
        for (int t = 0; t < 4000 && !seen_done; t++) begin
            nlow = 0;
            for (int k = 0; k < NS; k++) begin
                if (!csb0[k]) begin
                    nlow++;
                    if (k == int'(v.sel)) acc++; else foreign++;
                end
            end
            if (nlow > 1) multi++;
            if (!web0 && nlow > 0 && wmask0 != 4'hF) badmask++;
            if (busy) cyc++;
            if (done) begin
                seen_done = 1; busy_at_done = busy;
            end else begin
                start = (t == 3);
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen_done), 1);
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'(v.e_busy));
        chk({tag, "_busy_at_done"}, 64'(busy_at_done), 0);
        chk({tag, "_pass"}, 64'(pass), 64'(v.e_pass));
        chk({tag, "_err_count"}, 64'(err_count), 64'(v.e_err));
        chk({tag, "_fail_addr"}, 64'(fail_addr), 64'(v.e_faddr));
        chk({tag, "_fail_data"}, 64'(fail_data), 64'(v.e_fdata));
        chk({tag, "_fail_element"}, 64'(fail_element), 64'(v.e_felem));
        chk({tag, "_accesses"}, 64'(acc), 64'(v.e_acc));
        chk({tag, "_foreign_cs"}, 64'(foreign), 0);
        chk({tag, "_multi_cs"}, 64'(multi), 0);
        chk({tag, "_wmask"}, 64'(badmask), 0);
        repeat (2) @(negedge clk);
        chk({tag, "_done_sticky"}, 64'(done), 1);
        chk({tag, "_idle_csb0"}, 64'(csb0), 64'hFFFF);
        chk({tag, "_idle_busy"}, 64'(busy), 0);
    endtask

    vec_t vt [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk(2, 3, 32'h0, 0, 0, 0, 32'h0, 64, 1, 0, 0, 32'h0, 0, 40);
        vt[1] = mk(5, 3, 32'h0, 0, 1, 2, 32'h1, 64, 0, 3, 2, 32'h1, 1, 40);
        vt[2] = mk(5, 3, 32'h0, 1, 1, 2, 32'h1, 13, 0, 1, 2, 32'h1, 1, 9);
        vt[3] = mk(16, 3, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
        vt[4] = mk(15, 0, 32'hA5A5A5A5, 0, 0, 0, 32'h0, 16, 1, 0, 0, 32'h0, 0, 10);
        vt[5] = mk(7, 1, 32'hFFFFFFFF, 0, 1, 0, 32'h1, 32, 0, 2, 0, 32'h1, 2, 20);
        for (int i = 6; i < 12; i++) begin
            vec_t r;
            r = mk($urandom_range(0, 15), $urandom_range(0, 31), $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0, 32'h1 << $urandom_range(0, 31), 0, 0, 0, 0, 32'h0, 0, 0);
            r.faddr = AW'($urandom_range(0, int'(r.depth)));
            vt[i] = model(r);
        end

        #13;
        chk_reset_vals("reset");
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Async reset while M3 is running, then a fresh clean run.
        launch(mk(3, 3, 32'h0F0F1234, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0));
        repeat (31) @(negedge clk);
        chk("mid_busy", 64'(busy), 1);
        #2 resetn = 1'b0;
        #1 chk_reset_vals("midreset");
        @(negedge clk);
        resetn = 1'b1;
        run_vec(vt[0], "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Parametrised March C- built-in self-test engine for the OpenRAM testchip's SRAM macros.
- Owns the shared port-0 control/data bus (addr0/din0/web0/wmask0) and one active-low chip select per macro.
- Exercises one selected macro at a time, compares read data in hardware and reports pass/fail, error count and first-failure details.
- Generalises the fixed-width, fixed-count capture path to any address width, data width, macro count and read latency.

Parameters:
ADDR_WIDTH, 10, address bits driven on addr0
DATA_WIDTH, 32, data bits per macro word
WMASK_WIDTH, 4, write-mask bits (DATA_WIDTH/8)
NUM_SRAMS, 16, number of macros / csb0 bits
READ_LATENCY, 1, cycles from the read-issue cycle to valid data on dout_in (>=1)
SEL_WIDTH, $clog2(NUM_SRAMS), width of sram_sel

Ports:
clk  in  1  single clock, also clocks the macros
resetn  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; accepted only when busy=0
sram_sel  in  SEL_WIDTH  macro under test; latched at start
depth_m1  in  ADDR_WIDTH  last address tested (depth-1); latched at start
pattern  in  DATA_WIDTH  background "0" word; "1" = ~pattern; latched at start
stop_on_fail  in  1  abort on first mismatch; latched at start
dout_in  in  NUM_SRAMS*DATA_WIDTH  flattened macro dout0 buses; macro k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
addr0  out  ADDR_WIDTH  shared address
din0  out  DATA_WIDTH  shared write data
web0  out  1  write enable, active low
wmask0  out  WMASK_WIDTH  byte mask
csb0  out  NUM_SRAMS  per-macro chip select, active low; at most one bit low
busy  out  1  test in progress
done  out  1  sticky; set at test end, cleared at next accepted start
pass  out  1  valid when done=1
err_count  out  16  mismatch count, saturates at 16'hFFFF
fail_addr  out  ADDR_WIDTH  address of first mismatch
fail_data  out  DATA_WIDTH  data read at first mismatch
fail_element  out  3  march element index (0-5) of first mismatch

Behaviour:
- All outputs are registered.
- Reset values:
  - csb0 = all 1s, web0 = 1.
  - addr0 = 0, din0 = 0, wmask0 = 0.
  - busy = 0, done = 0, pass = 0.
  - err_count = 0, fail_addr = 0, fail_data = 0, fail_element = 0.
- Async resetn mid-test: return immediately to IDLE with the reset values above; any in-flight macro access is abandoned.
- March elements, with D = depth_m1 + 1:
  - M0 up: w0.
  - M1 up: r0, w1.
  - M2 up: r1, w0.
  - M3 down: r0, w1.
  - M4 down: r1, w0.
  - M5 up: r0.
  - Up runs 0..depth_m1; down runs depth_m1..0. The element ends on address equality; there is no wrap-around.
- States: IDLE, WRITE, READ, WAIT, CMP, DONE.
- IDLE:
  - start accepted: latch inputs, clear done/pass/err_count/fail_*, set busy, go to WRITE (element 0, addr 0) next cycle.
  - If sram_sel >= NUM_SRAMS at start: no macro access; next cycle done=1, pass=0, busy=0.
- WRITE (M0 only): csb0[sel]=0, web0=0, wmask0=all 1s, din0=pattern. One cycle per address.
- READ: csb0[sel]=0, web0=1, addr0=current address.
- WAIT: csb0 all high for READ_LATENCY cycles.
- CMP:
  - Compare the dout_in slice for sel against the expected word.
  - If the element has a write, the same cycle drives the write (csb0[sel]=0, web0=0, din0 = written value).
  - M5 CMP cycle: no access.
- Cycle budget:
  - Read/write elements take 2+READ_LATENCY cycles per address.
  - busy is high for exactly D + 5*D*(2+READ_LATENCY) cycles.
  - done=1, busy=0 on the following cycle (DONE), then back to IDLE.
- Mismatch handling:
  - Every mismatch increments err_count, saturating.
  - The first mismatch only captures fail_addr/fail_data/fail_element.
  - With stop_on_fail=1, the first mismatch goes to DONE next cycle with no write issued that cycle.
- pass = (err_count == 0) at DONE.
- start while busy = 1 is ignored.
- Input changes after start have no effect.
- csb0 is never low for more than one macro.

Decomposition:
- Package sram_bist_pkg:
  - state enum.
  - march element descriptor (direction, read-expect value, has-write, write value).
  - constant 6-entry March C- table.
  - ERR_W = 16.
- Sub-module sram_bist_addr_gen:
  - up/down address counter with load (0 or depth_m1).
  - last-address flag.

Test Plan:
- Clean macro model, sel=2, depth_m1=3, pattern=32'h0, READ_LATENCY=1 -> busy high 64 cycles, done=1, pass=1, err_count=0, every write touches only csb0[2].
- Stuck-at-1 bit0 at addr 2, pattern=0, stop_on_fail=0 -> err_count=3 (M1, M3, M5 reads of 0), fail_addr=2, fail_element=1, fail_data=32'h1, pass=0.
- Same fault with stop_on_fail=1 -> done on the cycle after the M1 CMP at addr 2, err_count=1, no further csb0 activity.
- sram_sel=16 with NUM_SRAMS=16 -> done=1, pass=0 one cycle after start, csb0 stays 16'hFFFF.
- resetn low during M3 -> all outputs at reset values immediately; a new start runs a full, clean test.
- start pulsed while busy and inputs changed mid-test -> ignored; results match the latched sel/depth/pattern.
